bitmap_loader: RTL
==================

// Module: bitmap_loader
// PURPOSE
//  Write-side companion of the bitmap character memory. Accepts one start command
//  plus a stream of 256 pixel words for a 16x16 character tile and writes them
//  row-major into the writable bitmap RAM at char_idx*256. Sits between the
//  MIPS memory-mapped I/O / UART loader and the bitmap RAM write port.
// PARAMETERS
//  PIX_W      12   bits per pixel, RGB 4:4:4
//  ADDR_W     12   bitmap RAM address width
//  NUM_CHARS  4    tiles the RAM holds (1024 words / 256); legal char_idx 0..NUM_CHARS-1
// PORTS
//  clk        in   1                rising-edge clock
//  reset_n    in   1                asynchronous, active-low reset
//  start      in   1                load request, sampled in IDLE only
//  char_idx   in   $clog2(NUM_CHARS)+1  destination tile, sampled with start
//  in_valid   in   1                pixel stream valid
//  in_ready   out  1                pixel stream ready
//  in_pixel   in   PIX_W            pixel value
//  abort      in   1                cancel current load
//  wr_en      out  1                RAM write strobe
//  wr_addr    out  ADDR_W           RAM write address
//  wr_data    out  PIX_W            RAM write data
//  busy       out  1                high in LOAD and DONE
//  done       out  1                one-cycle pulse: tile complete
//  err        out  1                one-cycle pulse: start with char_idx >= NUM_CHARS
//  cksum      out  PIX_W            XOR checksum (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE; all outputs 0; pixel counter 0; base 0.
//  - FSM states IDLE, LOAD, DONE.
//    IDLE: start && char_idx<NUM_CHARS -> LOAD, base<=char_idx*256, cnt<=0.
//          start && char_idx>=NUM_CHARS -> stay IDLE, err=1 next cycle (1 cycle).
//    LOAD: in_ready = !abort (combinational). Handshake = in_valid && in_ready.
//          On handshake: next cycle wr_en=1, wr_addr=base+cnt, wr_data=in_pixel; cnt++.
//          Handshake with cnt==255 -> DONE. abort -> IDLE, no done, cnt cleared;
//          abort wins over a same-cycle in_valid (pixel not accepted, not written).
//    DONE: done=1 for exactly one cycle, then IDLE. Last wr_en coincides with done.
//  - Latency: handshake to wr_en = 1 cycle; write outputs are registered.
//  - wr_en=0 on cycles without a handshake; wr_addr/wr_data hold last value.
//  - start while busy is ignored (no err, no restart).
//  - in_valid in IDLE/DONE: in_ready=0, nothing accepted.
//  - Address arithmetic: wr_addr = {char_idx, cnt[7:0]} zero-extended to ADDR_W;
//    never wraps into a neighbouring tile.
//  - Pixels already written before abort or reset stay in RAM (no rollback).
// CONFIGURATION
//  BITMAP_LOADER_CKSUM_EN defined: cksum cleared on entry to LOAD, XORed with each
//    accepted pixel; value stable from the done pulse until the next LOAD entry.
//  Not defined: checksum logic absent, cksum tied to 0. Port list unchanged.
// STRUCTURE
//  - Package bitmap_pkg: PIX_W, CHAR_PIX=256, CHAR_DIM=16, loader_state_t enum
//    {IDLE, LOAD, DONE}; shared with the bitmap RAM and VGA character renderer.
//  - Single module; no sub-module (counter + FSM + output register only).
// TESTING
//  1 Reset: assert reset_n=0 mid-LOAD at cnt=100 -> all outputs 0 at once, state IDLE.
//  2 Full load: start, char_idx=2, 256 pixels 0x000..0x0FF back-to-back -> wr_addr
//    0x200..0x2FF in order, wr_data==addr[7:0], done pulse with last write, busy=0 after.
//  3 Backpressure: in_valid toggled 1-0-1 randomly -> exactly 256 writes, no gaps in
//    address, no duplicates; start pulses while busy produce no effect.
//  4 Abort: abort at cnt=37 with in_valid=1 -> 37 writes only (0x000..0x024 for
//    idx 0), no done, next start reloads from cnt=0.
//  5 Illegal index: start, char_idx=4 -> err one cycle, busy stays 0, no writes.
//  6 Checksum (macro on): pixels 0xABC then 255x 0x000 -> cksum=0xABC at done;
//    macro off -> cksum=0 throughout.

Source files
------------

// File: rtl/bitmap_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : bitmap_pkg                                              |
// | Description: Shared constants and types for the bitmap character     |
// |              memory, its write-side loader and the VGA renderer.     |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
package bitmap_pkg;

  // Pixel width (RGB 4:4:4)
  localparam int PIX_W    = 12;
  // Pixels per character tile and tile edge length
  localparam int CHAR_PIX = 256;
  localparam int CHAR_DIM = 16;
  // Width of the in-tile pixel counter
  localparam int CNT_W    = $clog2(CHAR_PIX);

  // Loader control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage : bitmap_pkg
`default_nettype wire

// File: rtl/bitmap_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : bitmap_loader                                           |
// | Description: Write-side companion of the bitmap character memory.    |
// |              Takes a start command plus 256 pixel words for a 16x16  |
// |              tile and writes them row-major at char_idx*256.         |
// | Options    : BITMAP_LOADER_CKSUM_EN enables the XOR pixel checksum;  |
// |              without it cksum is tied to zero.                       |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module bitmap_loader #(
  parameter int PIX_W     = 12,
  parameter int ADDR_W    = 12,
  parameter int NUM_CHARS = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [$clog2(NUM_CHARS):0]  char_idx,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PIX_W-1:0]            in_pixel,
  input  logic                        abort,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [PIX_W-1:0]            wr_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [PIX_W-1:0]            cksum
);

  import bitmap_pkg::*;

  // Tile index width as seen on the char_idx port
  localparam int IDX_W = $clog2(NUM_CHARS) + 1;
  // Number of tiles, sized to compare directly against char_idx
  localparam logic [IDX_W-1:0] C_NUM_CHARS = IDX_W'(NUM_CHARS);
  // Counter value of the final pixel in a tile
  localparam logic [CNT_W-1:0] C_LAST_PIX  = CNT_W'(CHAR_PIX - 1);

  loader_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   base_q, base_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]   wr_data_q, wr_data_d;
  logic               err_q, err_d;

  logic               idx_legal;
  logic               load_entry;
  logic               handshake;

  // Stream handshake and command decode; abort blocks acceptance in the same cycle
  always_comb begin
    in_ready   = (state_q == LOAD) && !abort;
    handshake  = in_valid && in_ready;
    idx_legal  = (char_idx < C_NUM_CHARS);
    load_entry = (state_q == IDLE) && start && idx_legal;
  end

  // Next-state, counter and registered write-port computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (idx_legal) begin
            state_d = LOAD;
            base_d  = char_idx;
            cnt_d   = '0;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (handshake) begin
          // Address is the tile index concatenated with the in-tile offset,
          // so a load can never spill into the neighbouring tile.
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_W'({base_q, cnt_q});
          wr_data_d = in_pixel;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == C_LAST_PIX) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and write-port registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

`ifdef BITMAP_LOADER_CKSUM_EN
  logic [PIX_W-1:0] cksum_q, cksum_d;

  // Running XOR of accepted pixels, restarted each time a load begins
  always_comb begin
    cksum_d = cksum_q;
    if (load_entry) begin
      cksum_d = '0;
    end else if (handshake) begin
      cksum_d = cksum_q ^ in_pixel;
    end
  end

  // Checksum register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif

  // Status and write-port outputs; done is the single DONE-state cycle
  always_comb begin
    wr_en   = wr_en_q;
    wr_addr = wr_addr_q;
    wr_data = wr_data_q;
    err     = err_q;
    done    = (state_q == DONE);
    busy    = (state_q == LOAD) || (state_q == DONE);
  end

endmodule : bitmap_loader
`default_nettype wire
